// File: rtl/uart8_tx_feeder.sv
// uart8_tx_feeder: byte FIFO in front of an 8-bit UART transmitter, clocked by the baud clock.
// Bytes arrive on a valid/ready port. The FIFO head drives tx_in, and tx_start/tx_en are driven
// so that frames stream back-to-back. A head byte is consumed when the transmitter captures it.
// Capture is seen as a busy rise (idle capture) or as a done rise while start was already
// asserted (back-to-back capture on the first stop-bit cycle).
//
// Ports:
//   clk, rst_n        baud clock, synchronous active-low reset
//   wr_valid/wr_data  producer byte, accepted when wr_ready (= !full)
//   level             FIFO occupancy, 0..DEPTH
//   tx_busy, tx_done  transmitter status inputs
//   tx_en, tx_start   transmitter enable (low = transmitter reset) and start request
//   tx_in             FIFO head, 8'h00 when the FIFO is empty
//   idle              FIFO empty, transmitter not busy, no start pending
//
// Optional feature, enabled by defining UART8_TX_FEEDER_STATS_EN:
//   frames_sent       wrapping 16-bit count of capture events
//   overflow_attempt  sticky flag, set by a write attempted while full
module uart8_tx_feeder #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  output logic [AW:0]   level,
`ifdef UART8_TX_FEEDER_STATS_EN
  output logic [15:0]   frames_sent,
  output logic          overflow_attempt,
`endif
  input  logic          tx_busy,
  input  logic          tx_done,
  output logic          tx_en,
  output logic          tx_start,
  output logic [7:0]    tx_in,
  output logic          idle
);

  localparam logic [AW:0]   LevelFull = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LevelOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          tx_en_q;
  logic          tx_start_q, tx_start_d;
  logic          start_q;
  logic          hold_q, hold_d;
  logic          busy_q, done_q;
  logic          full, push, ev_a, ev_b, pop;

  assign full = (level_q == LevelFull);
  assign push = wr_valid & ~full;

  // A: capture from the transmitter's idle state (busy rises).
  // B: back-to-back capture on the first stop-bit cycle (done rises while start was held).
  assign ev_a = ~busy_q & tx_busy;
  assign ev_b = ~done_q & tx_done & start_q;
  assign pop  = (ev_a | ev_b) & (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    if (push && !pop) begin
      level_d = level_q + LevelOne;
    end else if (!push && pop) begin
      level_d = level_q - LevelOne;
    end
    // Hold start through the extra mark cycle after a back-to-back capture, so a
    // non-turbo transmitter does not abort to reset when the FIFO just emptied.
    hold_d     = ev_b;
    tx_start_d = tx_en_q & ((level_d != '0) | hold_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      start_q    <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_en_q    <= 1'b1;
      tx_start_q <= tx_start_d;
      start_q    <= tx_start_q;
      hold_q     <= hold_d;
      busy_q     <= tx_busy;
      done_q     <= tx_done;
    end
  end

  // Storage is not reset; level gates what is visible.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef UART8_TX_FEEDER_STATS_EN
  logic [15:0] frames_q, frames_d;
  logic        ovf_q, ovf_d;

  always_comb begin
    frames_d = frames_q;
    if (ev_a | ev_b) begin
      frames_d = frames_q + 16'd1;
    end
    ovf_d = ovf_q | (wr_valid & full);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frames_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      frames_q <= frames_d;
      ovf_q    <= ovf_d;
    end
  end

  assign frames_sent      = frames_q;
  assign overflow_attempt = ovf_q;
`endif

  assign wr_ready = ~full;
  assign level    = level_q;
  assign tx_en    = tx_en_q;
  assign tx_start = tx_start_q;
  assign tx_in    = (level_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign idle     = (level_q == '0) & ~tx_busy & ~tx_start_q;

  // hold_q mirrors hold_d; kept as a flop so the hold window is visible in waveforms.
  logic unused_hold;
  assign unused_hold = hold_q;

endmodule

// File: tb/tb_uart8_tx_feeder.sv
// Bench for uart8_tx_feeder: a behavioural 8-bit UART transmitter model consumes tx_start/tx_in,
// a serial-line monitor decodes frames and compares them against a scoreboard of pushed bytes.
module tb_uart8_tx_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_ready;
  logic [4:0]  level;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_en;
  logic        tx_start;
  logic [7:0]  tx_in;
  logic        idle;
`ifdef UART8_TX_FEEDER_STATS_EN
  logic [15:0] frames_sent;
  logic        overflow_attempt;
`endif

  uart8_tx_feeder #(.DEPTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_valid         (wr_valid),
    .wr_data          (wr_data),
    .wr_ready         (wr_ready),
    .level            (level),
`ifdef UART8_TX_FEEDER_STATS_EN
    .frames_sent      (frames_sent),
    .overflow_attempt (overflow_attempt),
`endif
    .tx_busy          (tx_busy),
    .tx_done          (tx_done),
    .tx_en            (tx_en),
    .tx_start         (tx_start),
    .tx_in            (tx_in),
    .idle             (idle)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  sb_q[$];
  int          gaps_q[$];
  int          exp_frames = 0;
  bit          turbo = 1'b1;
  bit          tx_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: idle capture sets busy; done is high on the first stop cycle, where a
  // pending start captures the next byte. Non-turbo adds a second mark cycle and aborts to
  // reset there if start is low.
  typedef enum int {MRst, MIdle, MStart, MData, MStop, MStop2} m_st_e;
  m_st_e      m_st = MRst;
  logic [7:0] m_shreg = 8'h00;
  int         m_bit = 0;
  logic       ser_line = 1'b1;

  always @(posedge clk) begin
    if (tx_en !== 1'b1 || tx_stall) begin
      m_st     <= MRst;
      ser_line <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      case (m_st)
        MRst: m_st <= MIdle;
        MIdle: begin
          if (tx_start === 1'b1) begin
            check("capture_nonempty", 32'(level != 5'd0), 32'd1);
            m_shreg  <= tx_in;
            tx_busy  <= 1'b1;
            ser_line <= 1'b0;
            m_st     <= MStart;
          end
        end
        MStart: begin
          ser_line <= m_shreg[0];
          m_bit    <= 0;
          m_st     <= MData;
        end
        MData: begin
          if (m_bit == 7) begin
            ser_line <= 1'b1;
            tx_done  <= 1'b1;
            m_st     <= MStop;
          end else begin
            ser_line <= m_shreg[m_bit+1];
            m_bit    <= m_bit + 1;
          end
        end
        MStop: begin
          tx_done <= 1'b0;
          if (tx_start === 1'b1) begin
            check("capture_nonempty", 32'(level != 5'd0), 32'd1);
            m_shreg <= tx_in;
            if (turbo) begin
              ser_line <= 1'b0;
              m_st     <= MStart;
            end else begin
              m_st <= MStop2;
            end
          end else begin
            tx_busy <= 1'b0;
            m_st    <= MIdle;
          end
        end
        MStop2: begin
          check("stop2_start_held", 32'(tx_start), 32'd1);
          if (tx_start === 1'b1) begin
            ser_line <= 1'b0;
            m_st     <= MStart;
          end else begin
            tx_busy <= 1'b0;
            m_st    <= MRst;
          end
        end
        default: m_st <= MRst;
      endcase
    end
  end

  // Serial monitor: decodes frames, records mark-cycle gaps between consecutive frames.
  int         rx_st = 0;
  int         rx_n = 0;
  int         gap = 99;
  logic [7:0] rx_byte = 8'h00;

  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || tx_en !== 1'b1) begin
        rx_st = 0;
        gap   = 99;
      end else begin
        case (rx_st)
          0: begin
            if (ser_line === 1'b0) begin
              if (gap < 16) gaps_q.push_back(gap);
              rx_st = 1;
              rx_n  = 0;
            end else if (gap < 99) begin
              gap++;
            end
          end
          1: begin
            rx_byte[rx_n] = ser_line;
            rx_n++;
            if (rx_n == 8) rx_st = 2;
          end
          default: begin
            check("stop_bit", 32'(ser_line), 32'd1);
            if (sb_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_frame: got %0h, expected no frame", rx_byte);
            end else begin
              exp_b = sb_q.pop_front();
              check("frame_byte", 32'(rx_byte), 32'(exp_b));
            end
            rx_st = 0;
            gap   = 1;
          end
        endcase
      end
    end
  end

  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(idle === 1'b1 && sb_q.size() == 0 && rx_st == 0) && k < budget);
    n_chk++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s: not drained after %0d cycles, %0d frames outstanding", name, k,
               sb_q.size());
    end
  endtask

  task automatic burst(input bit t);
    turbo = t;
    repeat (20) @(negedge clk);
    gaps_q.delete();
    for (int i = 1; i <= 4; i++) begin
      push(8'(i));
      sb_q.push_back(8'(i));
      exp_frames++;
    end
    wait_idle(200, t ? "burst_turbo_drain" : "burst_slow_drain");
    check("burst_gap_count", 32'(gaps_q.size()), 32'd3);
    for (int i = 0; i < gaps_q.size(); i++) begin
      check(t ? "gap_turbo" : "gap_slow", 32'(gaps_q[i]), t ? 32'd1 : 32'd2);
    end
`ifdef UART8_TX_FEEDER_STATS_EN
    check("frames_sent_burst", 32'(frames_sent), 32'(exp_frames));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 edges with a write offered: nothing may land.
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_in", 32'(tx_in), 32'h00);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
`ifdef UART8_TX_FEEDER_STATS_EN
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_ovf", 32'(overflow_attempt), 32'd0);
`endif
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    @(negedge clk);
    check("tx_en_after_rst", 32'(tx_en), 32'd1);
    check("no_write_in_rst", 32'(level), 32'd0);

    // Single byte to an idle transmitter.
    push(8'hA5);
    sb_q.push_back(8'hA5);
    exp_frames++;
    @(negedge clk);
    check("single_level", 32'(level), 32'd1);
    check("single_tx_start", 32'(tx_start), 32'd1);
    check("single_tx_in", 32'(tx_in), 32'hA5);
    check("single_idle", 32'(idle), 32'd0);
    repeat (2) @(negedge clk);
    check("single_popped", 32'(level), 32'd0);
    check("single_start_drop", 32'(tx_start), 32'd0);
    wait_idle(60, "single_drain");
    check("single_idle_end", 32'(idle), 32'd1);
    check("single_level_end", 32'(level), 32'd0);

    burst(1'b1);
    burst(1'b0);
`ifdef UART8_TX_FEEDER_STATS_EN
    check("ovf_before_fill", 32'(overflow_attempt), 32'd0);
`endif

    // Fill with the transmitter stalled, refuse a 17th write, then drain in order.
    turbo = 1'b1;
    repeat (5) @(negedge clk);
    tx_stall = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      push(8'hB0 + 8'(i));
      sb_q.push_back(8'hB0 + 8'(i));
      exp_frames++;
    end
    @(negedge clk);
    check("full_level", 32'(level), 32'd16);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    push(8'hEE);
    @(negedge clk);
    check("refused_level", 32'(level), 32'd16);
    check("full_head", 32'(tx_in), 32'hB0);
`ifdef UART8_TX_FEEDER_STATS_EN
    check("ovf_set", 32'(overflow_attempt), 32'd1);
`endif
    tx_stall = 1'b0;
    wait_idle(400, "fill_drain");
`ifdef UART8_TX_FEEDER_STATS_EN
    check("frames_after_fill", 32'(frames_sent), 32'(exp_frames));
`endif

    // Reset during data bit 4 of a frame with three bytes still queued.
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push(8'hC1 + 8'(i));
    end
    @(negedge clk);
    check("pre_reset_level", 32'(level), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    exp_frames = 0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_tx_en", 32'(tx_en), 32'd0);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
`ifdef UART8_TX_FEEDER_STATS_EN
    check("midrst_frames", 32'(frames_sent), 32'd0);
    check("midrst_ovf", 32'(overflow_attempt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h3C);
    sb_q.push_back(8'h3C);
    exp_frames++;
    wait_idle(80, "after_reset_drain");
    check("final_level", 32'(level), 32'd0);
`ifdef UART8_TX_FEEDER_STATS_EN
    check("final_frames", 32'(frames_sent), 32'(exp_frames));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
